// File: rtl/anfsqrt_ctrl.sv
// Integer square root / remainder controller for 7-bit radicands.
// Runs UNROLL chained bit-trial units per cycle between IDLE/RUN/DONE handshakes.
module anfsqrt_ctrl #(
    parameter int unsigned UNROLL   = 1,
    parameter bit          SKIP_MSB = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [6:0] in_rad,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [6:0] out_root,
    output logic [6:0] out_rem,
    output logic [2:0] out_cycles
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t     state, state_nx;
    logic [6:0] att, eps, res;
    logic [6:0] att_nx, eps_nx, res_nx;
    logic [2:0] cnt, cnt_nx;

    logic [6:0] c_att [UNROLL+1];
    logic [6:0] c_eps [UNROLL+1];
    logic [6:0] c_res [UNROLL+1];
    logic [6:0] this_att;
    logic [6:0] trial;
    logic [6:0] first_att;

    // att holds twice the root bit about to be tried, so 16 means "try bit 3".
    always_comb begin
        first_att = 7'd16;
        if (SKIP_MSB) begin
            if (in_rad >= 7'd64)      first_att = 7'd16;
            else if (in_rad >= 7'd16) first_att = 7'd8;
            else if (in_rad >= 7'd4)  first_att = 7'd4;
            else                      first_att = 7'd2;
        end
    end

    // Stages with nothing left to try (att <= 1) or nothing left to take (eps = 0) pass through.
    always_comb begin
        this_att = '0;
        trial    = '0;
        c_att[0] = att;
        c_eps[0] = eps;
        c_res[0] = res;
        for (int unsigned k = 0; k < UNROLL; k++) begin
            c_att[k+1] = c_att[k];
            c_eps[k+1] = c_eps[k];
            c_res[k+1] = c_res[k];
            if ((c_att[k] > 7'd1) && (c_eps[k] != '0)) begin
                this_att   = c_att[k] >> 1;
                trial      = ((c_res[k] << 1) + this_att) * this_att;
                c_att[k+1] = this_att;
                if (trial <= c_eps[k]) begin
                    c_eps[k+1] = c_eps[k] - trial;
                    c_res[k+1] = c_res[k] + this_att;
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        att_nx   = att;
        eps_nx   = eps;
        res_nx   = res;
        cnt_nx   = cnt;
        unique case (state)
            S_IDLE: begin
                if (in_valid) begin
                    eps_nx = in_rad;
                    res_nx = '0;
                    cnt_nx = '0;
                    if (in_rad == '0) begin
                        att_nx   = '0;
                        state_nx = S_DONE;
                    end else begin
                        att_nx   = first_att;
                        state_nx = S_RUN;
                    end
                end
            end
            S_RUN: begin
                att_nx = c_att[UNROLL];
                eps_nx = c_eps[UNROLL];
                res_nx = c_res[UNROLL];
                cnt_nx = cnt + 3'd1;
                if ((c_att[UNROLL] == 7'd1) || (c_eps[UNROLL] == '0)) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            att   <= '0;
            eps   <= '0;
            res   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            att   <= att_nx;
            eps   <= eps_nx;
            res   <= res_nx;
            cnt   <= cnt_nx;
        end
    end

    assign in_ready   = (state == S_IDLE);
    assign out_valid  = (state == S_DONE);
    assign out_root   = res;
    assign out_rem    = eps;
    assign out_cycles = cnt;

endmodule

// File: tb/tb_anfsqrt_ctrl.sv
// Self-checking bench: six anfsqrt_ctrl configurations (UNROLL 1/2/4 x SKIP_MSB 1/0),
// directed vectors, back-pressure, mid-RUN reset and an exhaustive randomized sweep.
module tb_anfsqrt_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       iv   [6];
    logic [6:0] ir   [6];
    logic       ordy [6];
    logic       irdy [6];
    logic       ov   [6];
    logic [6:0] oroot[6];
    logic [6:0] orem [6];
    logic [2:0] ocyc [6];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Config g: UNROLL = 1,1,2,2,4,4 ; SKIP_MSB = 1,0,1,0,1,0
    for (genvar g = 0; g < 6; g++) begin : g_dut
        anfsqrt_ctrl #(
            .UNROLL  ((g < 2) ? 1 : (g < 4) ? 2 : 4),
            .SKIP_MSB(g % 2 == 0)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (iv[g]),
            .in_ready  (irdy[g]),
            .in_rad    (ir[g]),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .out_root  (oroot[g]),
            .out_rem   (orem[g]),
            .out_cycles(ocyc[g])
        );
    end

    function automatic int unroll_of(input int g);
        return (g < 2) ? 1 : (g < 4) ? 2 : 4;
    endfunction

    // Reference: greedy root bits from the starting bit down, stopping once the
    // partial root squares to N exactly or bit 0 has been tried.
    function automatic void model(input int n, input int u, input bit skip,
                                  output int r, output int rm, output int c);
        int s, it, partial;
        r = 0;
        while ((r + 1) * (r + 1) <= n) r++;
        rm = n - r * r;
        if (n == 0) begin
            c = 0;
        end else begin
            s = 3;
            if (skip) begin
                s = 0;
                while ((1 << (s + 1)) * (1 << (s + 1)) <= n) s++;
            end
            it = 0;
            for (int k = s; k >= 0; k--) begin
                it++;
                partial = (r >> k) << k;
                if (k == 0 || partial * partial == n) break;
            end
            c = (it + u - 1) / u;
        end
    endfunction

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cfg=%0d actual=%0d expected=%0d", nm, g, act, exp);
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        for (int g = 0; g < 6; g++) begin
            iv[g] = 1'b0; ordy[g] = 1'b0; ir[g] = '0;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Called #1 after an edge with the DUT idle; returns #1 after the post-handshake edge.
    task automatic txn(input int g, input int n, input int er, input int erm, input int ec,
                       input bit rand_rdy);
        int  lat;
        bit  hs;
        chk("pre_ready", g, irdy[g], 1);
        iv[g] = 1'b1;
        ir[g] = 7'(n);
        @(posedge clk); #1;
        iv[g] = 1'b0;
        ir[g] = 7'($urandom);
        lat = 0;
        while (!ov[g] && lat < 8) begin
            chk("busy_ready", g, irdy[g], 0);
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", g, lat, ec);
        if (!ov[g]) begin
            pulse_reset();
            return;
        end
        chk("root", g, oroot[g], er);
        chk("rem", g, orem[g], erm);
        chk("cycles", g, ocyc[g], ec);
        chk("identity", g, oroot[g] * oroot[g] + orem[g], n);
        chk("rem_bound", g, (orem[g] <= 2 * oroot[g]), 1);
        hs = 1'b0;
        for (int w = 0; w < 32 && !hs; w++) begin
            ordy[g] = (!rand_rdy || w == 31) ? 1'b1 : 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (ordy[g]) begin
                hs = 1'b1;
            end else begin
                chk("hold_valid", g, ov[g], 1);
                chk("hold_root", g, oroot[g], er);
                chk("hold_rem", g, orem[g], erm);
                chk("hold_ready", g, irdy[g], 0);
            end
        end
        ordy[g] = 1'b0;
        chk("post_valid", g, ov[g], 0);
        chk("post_ready", g, irdy[g], 1);
    endtask

    typedef struct {
        int cfg;
        int n;
        int r;
        int rm;
        int c;
    } vec_t;

    vec_t tbl[11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int er, erm, ec, lat;
        tbl[0]  = '{0, 127, 11, 6, 4};
        tbl[1]  = '{0, 64, 8, 0, 1};
        tbl[2]  = '{1, 64, 8, 0, 1};
        tbl[3]  = '{0, 0, 0, 0, 0};
        tbl[4]  = '{2, 3, 1, 2, 1};
        tbl[5]  = '{0, 50, 7, 1, 3};
        tbl[6]  = '{0, 10, 3, 1, 2};
        tbl[7]  = '{4, 127, 11, 6, 1};
        tbl[8]  = '{5, 1, 1, 0, 1};
        tbl[9]  = '{3, 1, 1, 0, 2};
        tbl[10] = '{1, 127, 11, 6, 4};

        rst_n = 1'b0;
        for (int g = 0; g < 6; g++) begin
            iv[g] = 1'b0; ordy[g] = 1'b0; ir[g] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 6; g++) begin
            chk("rst_ready", g, irdy[g], 1);
            chk("rst_valid", g, ov[g], 0);
            chk("rst_root", g, oroot[g], 0);
            chk("rst_rem", g, orem[g], 0);
            chk("rst_cycles", g, ocyc[g], 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            txn(tbl[i].cfg, tbl[i].n, tbl[i].r, tbl[i].rm, tbl[i].c, 1'b0);
        end

        // Back-pressure with a competing request held during DONE
        iv[0] = 1'b1; ir[0] = 7'd50;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        lat = 0;
        while (!ov[0] && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_latency", 0, lat, 3);
        for (int w = 0; w < 10; w++) begin
            iv[0] = 1'b1; ir[0] = 7'd99;
            @(posedge clk); #1;
            chk("bp_valid", 0, ov[0], 1);
            chk("bp_root", 0, oroot[0], 7);
            chk("bp_rem", 0, orem[0], 1);
            chk("bp_cycles", 0, ocyc[0], 3);
            chk("bp_ready", 0, irdy[0], 0);
        end
        iv[0] = 1'b0; ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        chk("bp_release_valid", 0, ov[0], 0);
        chk("bp_release_ready", 0, irdy[0], 1);
        @(posedge clk); #1;
        chk("bp_no_accept", 0, irdy[0], 1);
        chk("bp_no_result", 0, ov[0], 0);

        // Reset during the second RUN cycle of a long computation
        iv[0] = 1'b1; ir[0] = 7'd127;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(posedge clk); #1;
        chk("mid_busy", 0, irdy[0], 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mid_rst_ready", 0, irdy[0], 1);
        chk("mid_rst_valid", 0, ov[0], 0);
        chk("mid_rst_root", 0, oroot[0], 0);
        chk("mid_rst_rem", 0, orem[0], 0);
        chk("mid_rst_cycles", 0, ocyc[0], 0);
        repeat (5) begin
            @(posedge clk); #1;
            chk("mid_rst_no_result", 0, ov[0], 0);
        end
        txn(0, 10, 3, 1, 2, 1'b0);

        // Exhaustive radicands for every configuration, random consumer readiness
        for (int g = 0; g < 6; g++) begin
            for (int n = 0; n < 128; n++) begin
                model(n, unroll_of(g), (g % 2 == 0), er, erm, ec);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #0;
                txn(g, n, er, erm, ec, 1'b1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
